// File: rtl/mult_mux_pipe_if.sv
// Handshake bundle for mult_mux_pipe: packed input channels with select on the
// input side, selected channel with error flag on the output side.
interface mult_mux_pipe_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
);
  localparam int SELW = $clog2(NCH);

  logic [NCH*WIDTH-1:0] in_data;
  logic [SELW-1:0]      in_sel;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_err;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_err, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_err, out_valid
  );
endinterface

// File: rtl/mult_mux_pipe.sv
// N-channel multiplier-based multiplexer with a PIPE-deep valid/ready pipeline.
// Optional MULTMUX_RR_EN: all-ones in_sel picks the channel from a round-robin counter.
module mult_mux_pipe #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int PIPE  = 2,
  parameter int SELW  = $clog2(NCH)
) (
  input logic            clk,
  input logic            n_reset,
  mult_mux_pipe_if.slave bus
);
  localparam int unsigned PW   = NCH * WIDTH;
  localparam int unsigned NCHU = NCH;

  logic                  adv;
  logic [SELW-1:0]       eff_sel;
  logic                  sel_err;
  logic [PW-1:0]         y;
  logic [2*PW-1:0]       prod;
  logic [WIDTH-1:0]      sel_data;
  logic [WIDTH-1:0]      data_q [PIPE];
  logic [PIPE-1:0]       vld_q;
  logic [PIPE-1:0]       err_q;

  assign adv           = !vld_q[PIPE-1] || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_data  = data_q[PIPE-1];
  assign bus.out_err   = err_q[PIPE-1];
  assign bus.out_valid = vld_q[PIPE-1];

`ifdef MULTMUX_RR_EN
  logic            auto_sel;
  logic [SELW-1:0] rr;

  assign auto_sel = (bus.in_sel == '1);
  assign eff_sel  = auto_sel ? rr : bus.in_sel;
  assign sel_err  = !auto_sel && (32'(bus.in_sel) >= NCHU);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rr <= '0;
    end else if (bus.in_valid && adv && auto_sel) begin
      rr <= (32'(rr) == NCHU - 1) ? '0 : rr + SELW'(1);
    end
  end
`else
  assign eff_sel = bus.in_sel;
  assign sel_err = (32'(bus.in_sel) >= NCHU);
`endif

  // Weight 2^((NCH-1-sel)*WIDTH) moves the chosen channel into the fixed window
  // at (NCH-1)*WIDTH of the product; an out-of-range select leaves y at zero.
  always_comb begin
    y = '0;
    for (int unsigned k = 0; k < NCHU; k++) begin
      if (32'(eff_sel) == k) begin
        y = PW'(1) << ((NCHU - 1 - k) * WIDTH);
      end
    end
    prod     = {PW'(0), bus.in_data} * {PW'(0), y};
    sel_data = WIDTH'(prod >> ((NCHU - 1) * WIDTH));
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      vld_q <= '0;
      err_q <= '0;
      for (int unsigned i = 0; i < PIPE; i++) begin
        data_q[i] <= '0;
      end
    end else if (adv) begin
      data_q[0] <= bus.in_valid ? sel_data : '0;
      vld_q[0]  <= bus.in_valid;
      err_q[0]  <= bus.in_valid && sel_err;
      for (int unsigned i = 1; i < PIPE; i++) begin
        data_q[i] <= data_q[i-1];
        vld_q[i]  <= vld_q[i-1];
        err_q[i]  <= err_q[i-1];
      end
    end
  end
endmodule

// File: tb/tb_mult_mux_pipe.sv
// Directed bench for mult_mux_pipe: four instances (NCH/PIPE variants) share one
// stimulus; expected values are hand-computed per cycle.
module tb_mult_mux_pipe;
  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        out_ready;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mult_mux_pipe_if #(.WIDTH(8), .NCH(4)) bus0 ();
  mult_mux_pipe_if #(.WIDTH(8), .NCH(3)) bus1 ();
  mult_mux_pipe_if #(.WIDTH(8), .NCH(4)) bus2 ();
  mult_mux_pipe_if #(.WIDTH(8), .NCH(4)) bus3 ();

  assign bus0.in_data = in_data;        assign bus0.in_sel = in_sel;
  assign bus0.in_valid = in_valid;      assign bus0.out_ready = out_ready;
  assign bus1.in_data = in_data[23:0];  assign bus1.in_sel = in_sel;
  assign bus1.in_valid = in_valid;      assign bus1.out_ready = out_ready;
  assign bus2.in_data = in_data;        assign bus2.in_sel = in_sel;
  assign bus2.in_valid = in_valid;      assign bus2.out_ready = out_ready;
  assign bus3.in_data = in_data;        assign bus3.in_sel = in_sel;
  assign bus3.in_valid = in_valid;      assign bus3.out_ready = out_ready;

  mult_mux_pipe #(.WIDTH(8), .NCH(4), .PIPE(2)) dut0 (.clk(clk), .n_reset(n_reset), .bus(bus0));
  mult_mux_pipe #(.WIDTH(8), .NCH(3), .PIPE(2)) dut1 (.clk(clk), .n_reset(n_reset), .bus(bus1));
  mult_mux_pipe #(.WIDTH(8), .NCH(4), .PIPE(1)) dut2 (.clk(clk), .n_reset(n_reset), .bus(bus2));
  mult_mux_pipe #(.WIDTH(8), .NCH(4), .PIPE(4)) dut3 (.clk(clk), .n_reset(n_reset), .bus(bus3));

`ifdef MULTMUX_RR_EN
  localparam logic [7:0] SEL3_D0  = 8'h11;  // first auto beat after reset -> channel 0
  localparam logic [7:0] T2_DATA  = 8'hAA;
  localparam logic       T2_ERR   = 1'b0;
`else
  localparam logic [7:0] SEL3_D0  = 8'h44;
  localparam logic [7:0] T2_DATA  = 8'h00;
  localparam logic       T2_ERR   = 1'b1;
`endif

  typedef struct {
    logic       v;
    logic [1:0] sel;
    logic       rdy;
    logic       ov;
    logic [7:0] od;
    logic       oe;
    logic       ir;
  } vec_t;

  vec_t       tbl [23];
  logic [1:0] rr_sel [6];
  logic [7:0] rr_exp [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Inputs change mid-cycle; outputs are sampled 1 time unit later.
  task automatic drive(input logic v, input logic [1:0] s, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_sel    = s;
    out_ready = r;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    tbl = '{
      // test 1: sel 0..3 back to back
      '{1'b1, 2'd0, 1'b1, 1'b0, 8'h00,    1'b0, 1'b1},
      '{1'b1, 2'd1, 1'b1, 1'b0, 8'h00,    1'b0, 1'b1},
      '{1'b1, 2'd2, 1'b1, 1'b1, 8'h11,    1'b0, 1'b1},
      '{1'b1, 2'd3, 1'b1, 1'b1, 8'h22,    1'b0, 1'b1},
      '{1'b0, 2'd0, 1'b1, 1'b1, 8'h33,    1'b0, 1'b1},
      '{1'b0, 2'd0, 1'b1, 1'b1, SEL3_D0,  1'b0, 1'b1},
      '{1'b0, 2'd0, 1'b1, 1'b0, 8'h00,    1'b0, 1'b1},
      // test 3: four beats, three-cycle stall when the first reaches the output
      '{1'b1, 2'd0, 1'b0, 1'b0, 8'h00,    1'b0, 1'b1},
      '{1'b1, 2'd1, 1'b1, 1'b0, 8'h00,    1'b0, 1'b1},
      '{1'b1, 2'd2, 1'b0, 1'b1, 8'h11,    1'b0, 1'b0},
      '{1'b1, 2'd2, 1'b0, 1'b1, 8'h11,    1'b0, 1'b0},
      '{1'b1, 2'd2, 1'b0, 1'b1, 8'h11,    1'b0, 1'b0},
      '{1'b1, 2'd2, 1'b1, 1'b1, 8'h11,    1'b0, 1'b1},
      '{1'b1, 2'd0, 1'b1, 1'b1, 8'h22,    1'b0, 1'b1},
      '{1'b0, 2'd0, 1'b1, 1'b1, 8'h33,    1'b0, 1'b1},
      '{1'b0, 2'd0, 1'b1, 1'b1, 8'h11,    1'b0, 1'b1},
      '{1'b0, 2'd0, 1'b1, 1'b0, 8'h00,    1'b0, 1'b1},
      // test 5: bubble pattern 1,0,1 at PIPE=2
      '{1'b1, 2'd0, 1'b1, 1'b0, 8'h00,    1'b0, 1'b1},
      '{1'b0, 2'd0, 1'b1, 1'b0, 8'h00,    1'b0, 1'b1},
      '{1'b1, 2'd1, 1'b1, 1'b1, 8'h11,    1'b0, 1'b1},
      '{1'b0, 2'd0, 1'b1, 1'b0, 8'h00,    1'b0, 1'b1},
      '{1'b0, 2'd0, 1'b1, 1'b1, 8'h22,    1'b0, 1'b1},
      '{1'b0, 2'd0, 1'b1, 1'b0, 8'h00,    1'b0, 1'b1}
    };
    rr_sel = '{2'd3, 2'd3, 2'd1, 2'd3, 2'd3, 2'd3};
`ifdef MULTMUX_RR_EN
    rr_exp = '{8'h11, 8'h22, 8'h22, 8'h33, 8'h44, 8'h11};
`else
    rr_exp = '{8'h44, 8'h44, 8'h22, 8'h44, 8'h44, 8'h44};
`endif

    in_data   = 32'h44332211;
    in_sel    = 2'd0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_ov0", {31'b0, bus0.out_valid}, 32'd0);
    chk("rst_od0", {24'b0, bus0.out_data}, 32'd0);
    chk("rst_oe0", {31'b0, bus0.out_err}, 32'd0);
    chk("rst_ov1", {31'b0, bus1.out_valid}, 32'd0);
    chk("rst_ov2", {31'b0, bus2.out_valid}, 32'd0);
    chk("rst_ov3", {31'b0, bus3.out_valid}, 32'd0);
    chk("rst_od3", {24'b0, bus3.out_data}, 32'd0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;

    // test 2: NCH=3, out-of-range select then a normal one
    in_data = 32'h00CCBBAA;
    drive(1'b1, 2'd3, 1'b1);
    drive(1'b1, 2'd1, 1'b1);
    drive(1'b0, 2'd0, 1'b1);
    chk("t2_ov_a", {31'b0, bus1.out_valid}, 32'd1);
    chk("t2_od_a", {24'b0, bus1.out_data}, {24'b0, T2_DATA});
    chk("t2_oe_a", {31'b0, bus1.out_err}, {31'b0, T2_ERR});
    drive(1'b0, 2'd0, 1'b1);
    chk("t2_ov_b", {31'b0, bus1.out_valid}, 32'd1);
    chk("t2_od_b", {24'b0, bus1.out_data}, 32'hBB);
    chk("t2_oe_b", {31'b0, bus1.out_err}, 32'd0);
    drive(1'b0, 2'd0, 1'b1);
    chk("t2_ov_c", {31'b0, bus1.out_valid}, 32'd0);
    in_data = 32'h44332211;
    repeat (4) drive(1'b0, 2'd0, 1'b1);

    // test 4: asynchronous reset with two beats in flight
    drive(1'b1, 2'd1, 1'b1);
    chk("t4_ov_pre0", {31'b0, bus0.out_valid}, 32'd0);
    drive(1'b1, 2'd2, 1'b1);
    chk("t4_ov_pre1", {31'b0, bus0.out_valid}, 32'd0);
    drive(1'b0, 2'd0, 1'b1);
    chk("t4_ov_live", {31'b0, bus0.out_valid}, 32'd1);
    chk("t4_od_live", {24'b0, bus0.out_data}, 32'h22);
    n_reset = 1'b0;
    #1;
    chk("t4_ov_rst", {31'b0, bus0.out_valid}, 32'd0);
    chk("t4_od_rst", {24'b0, bus0.out_data}, 32'd0);
    chk("t4_oe_rst", {31'b0, bus0.out_err}, 32'd0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 2'd0, 1'b1);
      chk($sformatf("t4_ghost0_%0d", i), {31'b0, bus0.out_valid}, 32'd0);
      chk($sformatf("t4_ghost3_%0d", i), {31'b0, bus3.out_valid}, 32'd0);
    end

    // tests 1, 3, 5 on the NCH=4, PIPE=2 instance
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].v, tbl[i].sel, tbl[i].rdy);
      chk($sformatf("tbl%0d_ov", i), {31'b0, bus0.out_valid}, {31'b0, tbl[i].ov});
      chk($sformatf("tbl%0d_ir", i), {31'b0, bus0.in_ready}, {31'b0, tbl[i].ir});
      if (tbl[i].ov) begin
        chk($sformatf("tbl%0d_od", i), {24'b0, bus0.out_data}, {24'b0, tbl[i].od});
        chk($sformatf("tbl%0d_oe", i), {31'b0, bus0.out_err}, {31'b0, tbl[i].oe});
      end
    end

    // test 5 at PIPE=1 and PIPE=4
    repeat (6) drive(1'b0, 2'd0, 1'b1);
    for (int k = 0; k < 9; k++) begin
      drive((k == 0) || (k == 2), (k == 0) ? 2'd0 : 2'd1, 1'b1);
      chk($sformatf("p1_ov%0d", k), {31'b0, bus2.out_valid}, {31'b0, (k == 1) || (k == 3)});
      chk($sformatf("p4_ov%0d", k), {31'b0, bus3.out_valid}, {31'b0, (k == 4) || (k == 6)});
      if (k == 1 || k == 3) begin
        chk($sformatf("p1_od%0d", k), {24'b0, bus2.out_data}, (k == 1) ? 32'h11 : 32'h22);
        chk($sformatf("p1_oe%0d", k), {31'b0, bus2.out_err}, 32'd0);
      end
      if (k == 4 || k == 6) begin
        chk($sformatf("p4_od%0d", k), {24'b0, bus3.out_data}, (k == 4) ? 32'h11 : 32'h22);
        chk($sformatf("p4_oe%0d", k), {31'b0, bus3.out_err}, 32'd0);
      end
    end

    // test 6: auto-select sequence with an interleaved explicit select
    @(negedge clk);
    n_reset = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k < 6) drive(1'b1, rr_sel[k], 1'b1);
      else       drive(1'b0, 2'd0, 1'b1);
      if (k >= 2 && k < 8) begin
        chk($sformatf("rr_ov%0d", k), {31'b0, bus0.out_valid}, 32'd1);
        chk($sformatf("rr_od%0d", k), {24'b0, bus0.out_data}, {24'b0, rr_exp[k-2]});
        chk($sformatf("rr_oe%0d", k), {31'b0, bus0.out_err}, 32'd0);
      end else begin
        chk($sformatf("rr_ov%0d", k), {31'b0, bus0.out_valid}, 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
